// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA raster generator: standard timing
// sets, the per-pixel control bundle carried down the latency pipe, and the
// colour-bar lookup used by the built-in test pattern.
package vga_pkg;

  // 640x400 @ 70 Hz: HS negative, VS positive
  localparam int V70_HZV = 640;
  localparam int V70_HZF = 16;
  localparam int V70_HZS = 96;
  localparam int V70_HZB = 48;
  localparam int V70_VTV = 400;
  localparam int V70_VTF = 12;
  localparam int V70_VTS = 2;
  localparam int V70_VTB = 35;
  localparam bit V70_HS_POL = 1'b0;
  localparam bit V70_VS_POL = 1'b1;

  // 640x480 @ 60 Hz: both syncs negative
  localparam int V60_HZV = 640;
  localparam int V60_HZF = 16;
  localparam int V60_HZS = 96;
  localparam int V60_HZB = 48;
  localparam int V60_VTV = 480;
  localparam int V60_VTF = 10;
  localparam int V60_VTS = 2;
  localparam int V60_VTB = 33;
  localparam bit V60_HS_POL = 1'b0;
  localparam bit V60_VS_POL = 1'b0;

  // Eight bars, {R,G,B} on/off per bar index
  typedef enum logic [2:0] {
    C_BLACK   = 3'b000,
    C_BLUE    = 3'b001,
    C_GREEN   = 3'b010,
    C_CYAN    = 3'b011,
    C_RED     = 3'b100,
    C_MAGENTA = 3'b101,
    C_YELLOW  = 3'b110,
    C_WHITE   = 3'b111
  } bar_colour_t;

  // Everything about one pixel that must arrive at the pins together with
  // its fetched colour.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vis;
    logic       mode;
    logic [2:0] rgb3;
  } pix_ctl_t;

  function automatic int seg_total(input int vis, input int fp,
                                   input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic bar_colour_t bar_colour(input logic [2:0] idx);
    bar_colour_t c;
    c = C_BLACK;
    case (idx)
      3'd0: c = C_BLACK;
      3'd1: c = C_BLUE;
      3'd2: c = C_GREEN;
      3'd3: c = C_CYAN;
      3'd4: c = C_RED;
      3'd5: c = C_MAGENTA;
      3'd6: c = C_YELLOW;
      3'd7: c = C_WHITE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-fetch side of the raster generator: request/coordinates out to the
// framebuffer or text renderer, fetched colour back, plus frame/line marks.
interface vga_sync_gen_if #(
  parameter int CW    = 4,
  parameter int CNT_W = 11
);
  logic             PREQ;
  logic [CNT_W-1:0] PX;
  logic [CNT_W-1:0] PY;
  logic             FRAME;
  logic             LINE;
  logic [3*CW-1:0]  PIX_RGB;

  modport master (output PREQ, PX, PY, FRAME, LINE, input PIX_RGB);
  modport slave  (input PREQ, PX, PY, FRAME, LINE, output PIX_RGB);
endinterface

// File: rtl/vga_delay.sv
// WIDTH x DEPTH shift register; clears to all-zero, which the raster
// generator treats as "sync inactive, not visible".
module vga_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per clock; async clear empties the whole pipe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA raster generator. Counters -> stage 0 (fetch request,
// raw sync/blank, bar colour) -> LAT-deep delay -> registered pins, so the
// fetched colour and the sync/blank of the same pixel leave together.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int HZV    = V70_HZV,
  parameter int HZF    = V70_HZF,
  parameter int HZS    = V70_HZS,
  parameter int HZB    = V70_HZB,
  parameter int VTV    = V70_VTV,
  parameter int VTF    = V70_VTF,
  parameter int VTS    = V70_VTS,
  parameter int VTB    = V70_VTB,
  parameter bit HS_POL = V70_HS_POL,
  parameter bit VS_POL = V70_VS_POL,
  parameter int LAT    = 2,
  parameter int CW     = 4,
  parameter int CNT_W  = 11
) (
  input  logic           CLOCK,
  input  logic           RESET_N,
  input  logic           TEST_MODE,
  vga_sync_gen_if.master fetch,
  output logic [CW-1:0]  VGA_R,
  output logic [CW-1:0]  VGA_G,
  output logic [CW-1:0]  VGA_B,
  output logic           VGA_HS,
  output logic           VGA_VS
);

  localparam int HZW = seg_total(HZV, HZF, HZS, HZB);
  localparam int VTW = seg_total(VTV, VTF, VTS, VTB);

  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("vga_sync_gen: LAT must be within 1..4");
  end
  if (HZW > 2**CNT_W || VTW > 2**CNT_W) begin : g_bad_cnt_w
    $error("vga_sync_gen: line or frame total does not fit CNT_W");
  end

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t X_LAST  = cnt_t'(HZW - 1);
  localparam cnt_t X_VIS0  = cnt_t'(HZB);
  localparam cnt_t X_VIS1  = cnt_t'(HZB + HZV);
  localparam cnt_t X_SYNC0 = cnt_t'(HZB + HZV + HZF);
  localparam cnt_t Y_LAST  = cnt_t'(VTW - 1);
  localparam cnt_t Y_VIS0  = cnt_t'(VTB);
  localparam cnt_t Y_VIS1  = cnt_t'(VTB + VTV);
  localparam cnt_t Y_SYNC0 = cnt_t'(VTB + VTV + VTF);

  cnt_t x_q, x_d, y_q, y_d;

  // Next raster position: X wraps every line, Y advances on the X wrap.
  always_comb begin
    x_d = x_q + cnt_t'(1);
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + cnt_t'(1);
    end
  end

  // Raster position registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  logic             vis_d;
  cnt_t             px_d, py_d;
  logic [CNT_W+2:0] px_x8;
  logic [2:0]       bar_idx;
  pix_ctl_t         ctl0_d;

  // Decode the current position. The bar index is floor(PX*8/HZV), found
  // by comparing PX*8 against the seven constant bar boundaries.
  always_comb begin
    vis_d   = (x_q >= X_VIS0) && (x_q < X_VIS1) && (y_q >= Y_VIS0) && (y_q < Y_VIS1);
    px_d    = x_q - X_VIS0;
    py_d    = y_q - Y_VIS0;
    px_x8   = {px_d, 3'b000};
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (px_x8 >= (CNT_W+3)'(i * HZV)) bar_idx = bar_idx + 3'd1;
    end
    ctl0_d.hs   = (x_q >= X_SYNC0);
    ctl0_d.vs   = (y_q >= Y_SYNC0);
    ctl0_d.vis  = vis_d;
    ctl0_d.mode = TEST_MODE;
    ctl0_d.rgb3 = bar_colour(bar_idx);
  end

  logic     preq_q, frame_q, line_q;
  cnt_t     px_q, py_q;
  pix_ctl_t ctl0_q, ctl_dly;

  // Stage 0: fetch request and markers, plus the control bundle entering
  // the delay pipe. TEST_MODE is sampled here so a change only affects
  // pixels not yet in flight.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      preq_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
      ctl0_q  <= '0;
    end else begin
      preq_q  <= vis_d;
      px_q    <= vis_d ? px_d : '0;
      py_q    <= vis_d ? py_d : '0;
      frame_q <= (x_q == '0) && (y_q == '0);
      line_q  <= (x_q == '0);
      ctl0_q  <= ctl0_d;
    end
  end

  vga_delay #(
    .WIDTH ($bits(pix_ctl_t)),
    .DEPTH (LAT)
  ) u_ctl_dly (
    .clk_i   (CLOCK),
    .rst_n_i (RESET_N),
    .d_i     (ctl0_q),
    .q_o     (ctl_dly)
  );

  logic [3*CW-1:0] rgb_d, rgb_q;
  logic            hs_q, vs_q;

  // Pick the pin colour; blanking overrides both the bars and fetched data.
  always_comb begin
    rgb_d = '0;
    if (ctl_dly.vis) begin
      rgb_d = ctl_dly.mode ? {{CW{ctl_dly.rgb3[2]}}, {CW{ctl_dly.rgb3[1]}}, {CW{ctl_dly.rgb3[0]}}}
                           : fetch.PIX_RGB;
    end
  end

  // Output stage: colour and polarity-adjusted syncs change on the same clock.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_q <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= ctl_dly.hs ? HS_POL : ~HS_POL;
      vs_q  <= ctl_dly.vs ? VS_POL : ~VS_POL;
    end
  end

  assign fetch.PREQ  = preq_q;
  assign fetch.PX    = px_q;
  assign fetch.PY    = py_q;
  assign fetch.FRAME = frame_q;
  assign fetch.LINE  = line_q;
  assign VGA_R       = rgb_q[3*CW-1:2*CW];
  assign VGA_G       = rgb_q[2*CW-1:CW];
  assign VGA_B       = rgb_q[CW-1:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Parametrised VGA raster generator, successor to the fixed 640x400 sync block. Produces HS/VS with configurable timings and polarities. Issues pixel-fetch requests (PREQ/PX/PY) ahead of the beam to a framebuffer or text renderer, and re-aligns the returned colour with delayed sync/blank so all pins change on the same pixel. Sits between the video memory fetch logic and the DAC pins; built-in colour-bar test mode.

Parameters:
HZV, 640, horizontal visible pixels
HZF, 16, horizontal front porch
HZS, 96, horizontal sync width
HZB, 48, horizontal back porch
VTV, 400, visible lines
VTF, 12, vertical front porch
VTS, 2, vertical sync lines
VTB, 35, vertical back porch
HS_POL, 0, HS active level (0 = negative sync)
VS_POL, 1, VS active level (1 = positive sync)
LAT, 2, fetch latency in clocks, legal 1..4
CW, 4, bits per colour channel
CNT_W, 11, X/Y counter width

Ports:
CLOCK  in  1  pixel clock
RESET_N  in  1  reset, asynchronous, active-low
TEST_MODE  in  1  1 = internal colour bars instead of PIX_RGB
PIX_RGB  in  3*CW  fetched colour {R,G,B}, valid LAT clocks after PREQ
PREQ  out  1  fetch request for pixel (PX,PY)
PX  out  CNT_W  visible column 0..HZV-1
PY  out  CNT_W  visible row 0..VTV-1
FRAME  out  1  one-clock pulse at X=0,Y=0
LINE  out  1  one-clock pulse at X=0
VGA_R, VGA_G, VGA_B  out  CW each  colour to DAC
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync

Behaviour:
- Clock/reset: one clock, CLOCK; RESET_N asynchronous, active-low.
- Counters: X counts 0..HZW-1 (HZW=HZV+HZF+HZS+HZB) and wraps to 0. Y increments only on the X wrap, counts 0..VTW-1 and wraps to 0.
- Segment order per line: back porch [0,HZB), visible [HZB,HZB+HZV), front porch, sync [HZB+HZV+HZF,HZW). The same order applies vertically with VTB/VTV/VTF/VTS.
- Stage 0 (registered from counters, valid one clock after counter value):
  - PREQ = visible(X,Y).
  - PX = X-HZB and PY = Y-VTB when PREQ, else 0.
  - FRAME = (X==0 && Y==0); LINE = (X==0).
- Delay lines: the raw hsync, vsync, visible and test-pattern colour (sampled with TEST_MODE at stage 0) pass through LAT-stage shift registers.
- Output stage, registered:
  - RGB = visible_d ? (mode_d ? bar_d : PIX_RGB) : 0.
  - VGA_HS = hsync_d ? HS_POL : ~HS_POL; VGA_VS likewise with VS_POL.
- Latency: counter to pins = LAT+2 clocks. PREQ high in clock m → PIX_RGB sampled in clock m+LAT → pins in clock m+LAT+1. Sync and colour of the same pixel appear on the same clock.
- Test bars: bar = PX*8/HZV (3 bits, computed with constant-divisor compare, no runtime divider). R = {CW{bar[2]}}, G = {CW{bar[1]}}, B = {CW{bar[0]}}.
- TEST_MODE change mid-line takes effect per pixel from stage 0; no glitch on the pixels already in flight.
- Reset (any time, including mid-frame): X=Y=0; PREQ=0; PX=PY=0; FRAME=LINE=0; RGB=0; HS/VS at inactive level; delay lines cleared to inactive/non-visible. The first FRAME pulse comes one clock after RESET_N deasserts.
- Blanking wins: non-visible pixels output 0 regardless of PIX_RGB or TEST_MODE.
- Elaboration error if LAT outside 1..4 or if HZW/VTW do not fit CNT_W.

Decomposition:
- Package vga_pkg holds:
  - timing constant sets: 640x400@70 (default above) and 640x480@60 (HZ 640/16/96/48, VT 480/10/2/33, both negative);
  - the colour-bar LUT;
  - a function computing HZW/VTW.
- Sub-module vga_delay: parametric WIDTH x DEPTH shift register with async active-low clear. It is instantiated for the sync/visible/bar bundle.

Test Plan:
- Reset mid-frame at X=300,Y=100: RGB=0, HS=1, VS=0, PREQ=0 immediately; after release, FRAME pulses in clock 1, and VGA_HS falls first at clock 704+LAT+2.
- Default timings: HS low exactly 96 clocks per 800; VS high exactly 2 lines (1600 clocks) per 449 lines; FRAME period 359200 clocks.
- PREQ count per frame = 256000. First PREQ at X=48,Y=35 with PX=0,PY=0; last has PX=639,PY=399.
- LAT=3, model returns PIX_RGB={PX[3:0],PY[3:0],4'hA} three clocks after PREQ: every visible pin pixel matches its coordinate, and porch pixels are 0.
- TEST_MODE=1: pixel PX=80 shows bar 1 (R=0,G=0,B=F); PX=639 shows white FFF. Toggling at PX=320 switches exactly at that pixel on the pins.
- HS_POL=1, VS_POL=0 with 640x480 set: HS high 96 clocks, VS low 2 lines, line period 800, frame period 420000 clocks.
